csb_apb_arbiter: RTL and testbench
==================================

# csb_apb_arbiter

Synthesizable two-port APB master arbiter. It shares the single NVDLA CSB/APB slave port between a command-stream requester (`cmd_*`) and an interrupt-service requester (`irq_*`), replacing the token handshake the simulation sequencer uses. Each transfer is carried out as one atomic APB read or write. Requester word addresses are converted to byte addresses. A stalled slave is bounded by a timeout.

## Interface
- `TIMEOUT`, 1024: max ACCESS cycles waiting for `pready_i` before abort; 0 disables the timeout.
- `IRQ_BURST`, 4: max consecutive irq grants while cmd is pending before cmd is forced one grant.
- `clk_i` in 1: single clock; all logic on its rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `cmd_req_i` / `irq_req_i` in 1: transfer request; held until the matching ack.
- `cmd_write_i` / `irq_write_i` in 1: 1 = write, 0 = read.
- `cmd_addr_i` / `irq_addr_i` in 16: word address.
- `cmd_wdata_i` / `irq_wdata_i` in 32: write data.
- `cmd_ack_o` / `irq_ack_o` out 1: one-cycle completion pulse.
- `cmd_rdata_o` / `irq_rdata_o` out 32: read data, valid while ack is high.
- `cmd_err_o` / `irq_err_o` out 1: timeout flag, valid while ack is high.
- `psel_o`, `penable_o`, `pwrite_o` out 1: APB control.
- `paddr_o` out 32: APB byte address, equal to `{14'b0, addr, 2'b00}`.
- `pwdata_o` out 32: APB write data.
- `prdata_i` in 32: APB read data.
- `pready_i` in 1: APB ready.

## Operation
- FSM states:
  - IDLE → SETUP: any req high and no ack issued this cycle. The grant is decided here. Addr, write and wdata of the winner are latched.
  - SETUP → ACCESS: unconditional.
  - ACCESS → DONE: `pready_i`=1. Captures `prdata_i` (reads only) and sets err=0.
  - ACCESS → DONE: wait counter reaches `TIMEOUT`. Sets rdata=0 and err=1.
  - DONE → IDLE: unconditional. The granted requester's ack is high during DONE.
- Arbitration:
  - irq has fixed priority over cmd.
  - `burst_cnt` counts consecutive irq grants made while cmd_req was high. It saturates at `IRQ_BURST`.
  - When `burst_cnt`=`IRQ_BURST` and both reqs are high, cmd wins and `burst_cnt` clears.
  - A cmd grant, or an irq grant with cmd_req low, clears `burst_cnt`.
- A transfer is never pre-empted; a request arriving mid-transfer waits.
- A req that drops before grant is ignored and no ack is issued for it. Requesters must not drop req after grant; if one does, the transfer still completes and the ack is still pulsed.
- A write transfer leaves `*_rdata_o` at its previous value.
- The wait counter is 32-bit. It clears on entry to ACCESS and increments each ACCESS cycle with `pready_i`=0.

## Timing
- Reset values: `psel_o`=0, `penable_o`=0, `pwrite_o`=0, `paddr_o`=0, `pwdata_o`=0, both acks 0, both errs 0, both rdata 0. FSM state is IDLE and `burst_cnt`=0.
- Reset asserted mid-transfer:
  - The next edge returns every output to its reset value.
  - No ack is issued for the aborted transfer.
- APB outputs are registered:
  - SETUP: `psel_o`=1, `penable_o`=0.
  - ACCESS: `psel_o`=1, `penable_o`=1.
  - DONE and IDLE: both 0.
- `paddr_o`, `pwrite_o` and `pwdata_o` are stable from SETUP through the last ACCESS cycle.
- Latency with req sampled in cycle N and zero-wait `pready_i`:
  - SETUP is N+1.
  - ACCESS is N+2.
  - DONE/ack is N+3.
- Each ACCESS wait state adds one cycle.
- Back-to-back throughput is one transfer per 4 cycles.
- Both reqs rising in the same cycle: irq wins (subject to `burst_cnt`).
- Timeout case: `TIMEOUT` wait cycles are followed by DONE with err=1. The slave sees `psel_o` drop without a `pready_i` handshake.

## Structure
- Shared package `csb_pkg` holds:
  - FSM state enum {IDLE, SETUP, ACCESS, DONE};
  - requester index localparams `REQ_CMD`=0, `REQ_IRQ`=1;
  - the NVDLA glb register word addresses `GLB_INTR_MASK`=16'h401 and `GLB_INTR_STATUS`=16'h403, used by the irq-side client.
- One sub-module, `csb_arb_pick`: combinational priority and starvation pick from the two reqs plus `burst_cnt`. Outputs are the grant index and a grant-valid flag.

## Test plan
- **Single cmd write:** addr 16'h401, wdata 32'h0000_0003.
  - `paddr_o`=32'h1004 in SETUP.
  - `penable_o` high in ACCESS.
  - `cmd_ack_o` pulses 3 cycles after req.
- **irq read with 2 wait states:** addr 16'h403, slave returns 32'h0000_0100. `irq_ack_o` comes at +5 cycles with `irq_rdata_o`=32'h100 and err=0.
- **Simultaneous reqs:** irq is granted first and cmd second; acks come 4 cycles apart.
- **Starvation guard:** `IRQ_BURST`=4, both reqs held high continuously. Grant order is irq ×4, cmd, irq ×4, cmd.
- **Timeout:** `TIMEOUT`=8 with `pready_i` stuck low. Ack comes after 8 ACCESS cycles with err=1 and rdata=0, then the next request is served normally.
- **Reset mid-ACCESS:** `rst_i` pulsed for one cycle.
  - All outputs return to 0 on the next edge.
  - No ack is issued.
  - A held req restarts from SETUP after reset deasserts.

Source files
------------

// File: rtl/csb_pkg.sv
// Shared definitions for the CSB/APB arbiter slice.
//   - csb_state_e : transfer FSM states (IDLE, SETUP, ACCESS, DONE)
//   - REQ_CMD / REQ_IRQ : requester indices used for the grant
//   - GLB_INTR_MASK / GLB_INTR_STATUS : NVDLA glb register word addresses
//     that the irq-side client targets
//   - word2byte() : requester word address to APB byte address
package csb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } csb_state_e;

  localparam logic REQ_CMD = 1'b0;
  localparam logic REQ_IRQ = 1'b1;

  localparam logic [15:0] GLB_INTR_MASK   = 16'h0401;
  localparam logic [15:0] GLB_INTR_STATUS = 16'h0403;

  function automatic logic [31:0] word2byte(input logic [15:0] word_addr);
    return {14'b0, word_addr, 2'b00};
  endfunction

endpackage

// File: rtl/csb_arb_pick.sv
// Combinational grant pick for the two CSB requesters.
// irq has fixed priority; once burst_cnt_i has reached IRQ_BURST while both
// requesters are asking, cmd is picked so it cannot starve.
// Ports:
//   cmd_req_i, irq_req_i : live request lines
//   burst_cnt_i          : consecutive irq grants made while cmd was pending
//   gnt_idx_o            : REQ_CMD or REQ_IRQ
//   gnt_vld_o            : at least one request is present
module csb_arb_pick
  import csb_pkg::*;
#(
  parameter int IRQ_BURST = 4,
  parameter int BW        = $clog2(IRQ_BURST + 1)
) (
  input  logic          cmd_req_i,
  input  logic          irq_req_i,
  input  logic [BW-1:0] burst_cnt_i,
  output logic          gnt_idx_o,
  output logic          gnt_vld_o
);

  localparam logic [BW-1:0] BURST_MAX = BW'(IRQ_BURST);

  logic starve;

  always_comb begin
    starve    = cmd_req_i && (burst_cnt_i >= BURST_MAX);
    gnt_vld_o = cmd_req_i | irq_req_i;
    gnt_idx_o = REQ_CMD;
    if (irq_req_i && !starve) begin
      gnt_idx_o = REQ_IRQ;
    end
  end

endmodule

// File: rtl/csb_apb_arbiter.sv
// Two-port APB master arbiter sharing the NVDLA CSB/APB slave between a
// command-stream requester (cmd_*) and an interrupt-service requester
// (irq_*). Every transfer is one atomic APB read or write; a slave that
// never raises pready_i is abandoned after TIMEOUT wait cycles.
// Ports:
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   {cmd,irq}_req_i              : request, held until matching ack
//   {cmd,irq}_write_i/addr_i/wdata_i : transfer description (word address)
//   {cmd,irq}_ack_o              : one-cycle completion pulse (DONE)
//   {cmd,irq}_rdata_o / err_o    : read data / timeout flag, valid with ack
//   psel_o, penable_o, pwrite_o, paddr_o, pwdata_o : registered APB master
//   prdata_i, pready_i           : APB slave response
module csb_apb_arbiter
  import csb_pkg::*;
#(
  parameter int TIMEOUT   = 1024,
  parameter int IRQ_BURST = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_req_i,
  input  logic        cmd_write_i,
  input  logic [15:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        cmd_ack_o,
  output logic [31:0] cmd_rdata_o,
  output logic        cmd_err_o,
  input  logic        irq_req_i,
  input  logic        irq_write_i,
  input  logic [15:0] irq_addr_i,
  input  logic [31:0] irq_wdata_i,
  output logic        irq_ack_o,
  output logic [31:0] irq_rdata_o,
  output logic        irq_err_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [31:0] paddr_o,
  output logic [31:0] pwdata_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i
);

  localparam int              BW        = $clog2(IRQ_BURST + 1);
  localparam logic [BW-1:0]   BURST_MAX = BW'(IRQ_BURST);
  localparam logic [31:0]     TIMEOUT_W = 32'(TIMEOUT);

  csb_state_e    state_q, state_d;
  logic          gnt_q, gnt_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [31:0]   wait_q, wait_d;

  logic          psel_q, psel_d;
  logic          penable_q, penable_d;
  logic          pwrite_q, pwrite_d;
  logic [31:0]   paddr_q, paddr_d;
  logic [31:0]   pwdata_q, pwdata_d;

  logic          cmd_ack_q, cmd_ack_d;
  logic          irq_ack_q, irq_ack_d;
  logic [31:0]   cmd_rdata_q, cmd_rdata_d;
  logic [31:0]   irq_rdata_q, irq_rdata_d;
  logic          cmd_err_q, cmd_err_d;
  logic          irq_err_q, irq_err_d;

  logic          pick_idx;
  logic          pick_vld;

  csb_arb_pick #(
    .IRQ_BURST (IRQ_BURST),
    .BW        (BW)
  ) u_pick (
    .cmd_req_i   (cmd_req_i),
    .irq_req_i   (irq_req_i),
    .burst_cnt_i (burst_q),
    .gnt_idx_o   (pick_idx),
    .gnt_vld_o   (pick_vld)
  );

  // All outputs are registered, so the next-state logic also computes the
  // output values that belong to the state being entered.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    burst_d     = burst_q;
    wait_d      = wait_q;
    psel_d      = 1'b0;
    penable_d   = 1'b0;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    cmd_ack_d   = 1'b0;
    irq_ack_d   = 1'b0;
    cmd_rdata_d = cmd_rdata_q;
    irq_rdata_d = irq_rdata_q;
    cmd_err_d   = cmd_err_q;
    irq_err_d   = irq_err_q;

    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = SETUP;
          gnt_d   = pick_idx;
          psel_d  = 1'b1;
          if (pick_idx == REQ_IRQ) begin
            pwrite_d = irq_write_i;
            paddr_d  = word2byte(irq_addr_i);
            pwdata_d = irq_wdata_i;
            // Only irq wins taken against a waiting cmd count toward the
            // starvation limit.
            if (cmd_req_i) begin
              burst_d = (burst_q == BURST_MAX) ? burst_q : burst_q + 1'b1;
            end else begin
              burst_d = '0;
            end
          end else begin
            pwrite_d = cmd_write_i;
            paddr_d  = word2byte(cmd_addr_i);
            pwdata_d = cmd_wdata_i;
            burst_d  = '0;
          end
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
        wait_d    = '0;
      end

      ACCESS: begin
        if (pready_i) begin
          state_d = DONE;
          if (gnt_q == REQ_IRQ) begin
            irq_ack_d = 1'b1;
            irq_err_d = 1'b0;
            if (!pwrite_q) irq_rdata_d = prdata_i;
          end else begin
            cmd_ack_d = 1'b1;
            cmd_err_d = 1'b0;
            if (!pwrite_q) cmd_rdata_d = prdata_i;
          end
        end else begin
          wait_d = wait_q + 32'd1;
          // Abort in the cycle the wait count reaches TIMEOUT, so exactly
          // TIMEOUT unanswered ACCESS cycles precede DONE.
          if ((TIMEOUT != 0) && (wait_d == TIMEOUT_W)) begin
            state_d = DONE;
            if (gnt_q == REQ_IRQ) begin
              irq_ack_d   = 1'b1;
              irq_err_d   = 1'b1;
              irq_rdata_d = '0;
            end else begin
              cmd_ack_d   = 1'b1;
              cmd_err_d   = 1'b1;
              cmd_rdata_d = '0;
            end
          end else begin
            psel_d    = 1'b1;
            penable_d = 1'b1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset clears every output as well as the control state, so an aborted
  // transfer leaves no trace on either requester port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      gnt_q       <= REQ_CMD;
      burst_q     <= '0;
      wait_q      <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      cmd_ack_q   <= 1'b0;
      irq_ack_q   <= 1'b0;
      cmd_rdata_q <= '0;
      irq_rdata_q <= '0;
      cmd_err_q   <= 1'b0;
      irq_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      burst_q     <= burst_d;
      wait_q      <= wait_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      cmd_ack_q   <= cmd_ack_d;
      irq_ack_q   <= irq_ack_d;
      cmd_rdata_q <= cmd_rdata_d;
      irq_rdata_q <= irq_rdata_d;
      cmd_err_q   <= cmd_err_d;
      irq_err_q   <= irq_err_d;
    end
  end

  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign pwrite_o    = pwrite_q;
  assign paddr_o     = paddr_q;
  assign pwdata_o    = pwdata_q;
  assign cmd_ack_o   = cmd_ack_q;
  assign irq_ack_o   = irq_ack_q;
  assign cmd_rdata_o = cmd_rdata_q;
  assign irq_rdata_o = irq_rdata_q;
  assign cmd_err_o   = cmd_err_q;
  assign irq_err_o   = irq_err_q;

endmodule

// File: tb/tb_csb_apb_arbiter.sv
// Directed bench for csb_apb_arbiter: a vector table of single transfers
// plus hand-written sequences for arbitration, starvation and reset.
module tb_csb_apb_arbiter;
  import csb_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_req_i = 1'b0, cmd_write_i = 1'b0;
  logic [15:0] cmd_addr_i = '0;
  logic [31:0] cmd_wdata_i = '0;
  logic        cmd_ack_o, cmd_err_o;
  logic [31:0] cmd_rdata_o;
  logic        irq_req_i = 1'b0, irq_write_i = 1'b0;
  logic [15:0] irq_addr_i = '0;
  logic [31:0] irq_wdata_i = '0;
  logic        irq_ack_o, irq_err_o;
  logic [31:0] irq_rdata_o;
  logic        psel_o, penable_o, pwrite_o;
  logic [31:0] paddr_o, pwdata_o;
  logic [31:0] prdata_i = '0;
  logic        pready_i = 1'b0;

  csb_apb_arbiter #(.TIMEOUT(8), .IRQ_BURST(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_req_i(cmd_req_i), .cmd_write_i(cmd_write_i), .cmd_addr_i(cmd_addr_i),
    .cmd_wdata_i(cmd_wdata_i), .cmd_ack_o(cmd_ack_o), .cmd_rdata_o(cmd_rdata_o),
    .cmd_err_o(cmd_err_o),
    .irq_req_i(irq_req_i), .irq_write_i(irq_write_i), .irq_addr_i(irq_addr_i),
    .irq_wdata_i(irq_wdata_i), .irq_ack_o(irq_ack_o), .irq_rdata_o(irq_rdata_o),
    .irq_err_o(irq_err_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o),
    .prdata_i(prdata_i), .pready_i(pready_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave model: answers after slave_wait ACCESS cycles unless stuck.
  int          slave_wait  = 0;
  logic        slave_stuck = 1'b0;
  logic [31:0] slave_rdata = '0;
  int          acc_cnt     = 0;

  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (psel_o && penable_o) begin
        pready_i = !slave_stuck && (acc_cnt >= slave_wait);
        prdata_i = slave_rdata;
        acc_cnt++;
      end else begin
        pready_i = 1'b0;
        acc_cnt  = 0;
      end
    end
  end

  typedef struct {
    logic        irq;
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic        stuck;
    logic [31:0] srdata;
    int          lat;
    logic [31:0] paddr;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_psel"},    32'(psel_o),    32'd0);
    chk({tag, "_penable"}, 32'(penable_o), 32'd0);
    chk({tag, "_pwrite"},  32'(pwrite_o),  32'd0);
    chk({tag, "_paddr"},   paddr_o,        32'd0);
    chk({tag, "_pwdata"},  pwdata_o,       32'd0);
    chk({tag, "_acks"},    {30'd0, cmd_ack_o, irq_ack_o}, 32'd0);
    chk({tag, "_errs"},    {30'd0, cmd_err_o, irq_err_o}, 32'd0);
    chk({tag, "_crdata"},  cmd_rdata_o,    32'd0);
    chk({tag, "_irdata"},  irq_rdata_o,    32'd0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   lat;
    logic seen, ack, other_ack;
    string p;
    p = $sformatf("v%0d", idx);
    slave_wait  = v.waits;
    slave_stuck = v.stuck;
    slave_rdata = v.srdata;
    if (v.irq) begin
      irq_write_i = v.wr; irq_addr_i = v.addr; irq_wdata_i = v.wdata; irq_req_i = 1'b1;
    end else begin
      cmd_write_i = v.wr; cmd_addr_i = v.addr; cmd_wdata_i = v.wdata; cmd_req_i = 1'b1;
    end
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      tick();
      lat++;
      if (lat == 1) begin
        chk({p, "_setup_psel"},    32'(psel_o),    32'd1);
        chk({p, "_setup_penable"}, 32'(penable_o), 32'd0);
        chk({p, "_setup_pwrite"},  32'(pwrite_o),  32'(v.wr));
        if (v.wr) chk({p, "_setup_pwdata"}, pwdata_o, v.wdata);
      end
      if (lat == 2) begin
        chk({p, "_access_psel"},    32'(psel_o),    32'd1);
        chk({p, "_access_penable"}, 32'(penable_o), 32'd1);
      end
      if (psel_o) chk({p, "_paddr"}, paddr_o, v.paddr);
      ack       = v.irq ? irq_ack_o : cmd_ack_o;
      other_ack = v.irq ? cmd_ack_o : irq_ack_o;
      if (ack) begin
        seen = 1'b1;
        chk({p, "_lat"},       32'(lat),       32'(v.lat));
        chk({p, "_rdata"},     v.irq ? irq_rdata_o : cmd_rdata_o, v.rdata);
        chk({p, "_err"},       32'(v.irq ? irq_err_o : cmd_err_o), 32'(v.err));
        chk({p, "_other_ack"}, 32'(other_ack), 32'd0);
        chk({p, "_done_psel"}, 32'(psel_o),    32'd0);
        cmd_req_i = 1'b0;
        irq_req_i = 1'b0;
      end
    end
    if (!seen) begin
      chk({p, "_lat"}, 32'(lat), 32'(v.lat));
      cmd_req_i = 1'b0;
      irq_req_i = 1'b0;
    end
    tick();
  endtask

  initial begin
    int   t_irq, t_cmd, cyc, nack;
    logic exp_irq;

    //          irq   wr    addr             wdata          w  stk   srdata         lat paddr          rdata          err
    vecs[0] = '{1'b0, 1'b1, GLB_INTR_MASK,   32'h0000_0003, 0, 1'b0, 32'h0,         3,  32'h0000_1004, 32'h0,         1'b0};
    vecs[1] = '{1'b1, 1'b0, GLB_INTR_STATUS, 32'h0,         2, 1'b0, 32'h0000_0100, 5,  32'h0000_100C, 32'h0000_0100, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 16'h0010,        32'h0,         1, 1'b0, 32'hDEAD_BEEF, 4,  32'h0000_0040, 32'hDEAD_BEEF, 1'b0};
    vecs[3] = '{1'b1, 1'b1, GLB_INTR_MASK,   32'hFFFF_FFFF, 0, 1'b0, 32'h5555_5555, 3,  32'h0000_1004, 32'h0000_0100, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 16'hFFFF,        32'h0,         0, 1'b1, 32'h7777_7777, 10, 32'h0003_FFFC, 32'h0,         1'b1};
    vecs[5] = '{1'b0, 1'b0, 16'h0002,        32'h0,         0, 1'b0, 32'h1234_5678, 3,  32'h0000_0008, 32'h1234_5678, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 16'h0000,        32'h0,         7, 1'b0, 32'hA5A5_A5A5, 10, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0};

    rst_i = 1'b1;
    tick(); tick(); tick();
    check_zero("reset");
    rst_i = 1'b0;
    tick();
    check_zero("idle");

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Simultaneous requests: irq first, cmd 4 cycles later.
    slave_wait = 0; slave_stuck = 1'b0; slave_rdata = 32'hCAFE_0001;
    cmd_write_i = 1'b0; cmd_addr_i = 16'h0004;
    irq_write_i = 1'b0; irq_addr_i = GLB_INTR_STATUS;
    cmd_req_i = 1'b1; irq_req_i = 1'b1;
    t_irq = 0; t_cmd = 0; cyc = 0;
    while ((t_irq == 0 || t_cmd == 0) && cyc < 40) begin
      tick();
      cyc++;
      if (irq_ack_o && t_irq == 0) begin t_irq = cyc; irq_req_i = 1'b0; end
      if (cmd_ack_o && t_cmd == 0) begin t_cmd = cyc; cmd_req_i = 1'b0; end
    end
    cmd_req_i = 1'b0; irq_req_i = 1'b0;
    chk("simul_irq_ack_cycle", 32'(t_irq), 32'd3);
    chk("simul_cmd_ack_cycle", 32'(t_cmd), 32'd7);
    tick();

    // Starvation guard: both requests held, order irq x4, cmd, irq x4, cmd.
    cmd_req_i = 1'b1; irq_req_i = 1'b1;
    nack = 0; cyc = 0;
    while (nack < 10 && cyc < 100) begin
      tick();
      cyc++;
      if (cmd_ack_o || irq_ack_o) begin
        exp_irq = !(nack == 4 || nack == 9);
        chk($sformatf("starve_grant%0d_irq", nack), 32'(irq_ack_o), 32'(exp_irq));
        chk($sformatf("starve_grant%0d_cmd", nack), 32'(cmd_ack_o), 32'(!exp_irq));
        nack++;
      end
    end
    cmd_req_i = 1'b0; irq_req_i = 1'b0;
    chk("starve_last_ack_cycle", 32'(cyc), 32'd39);
    tick();

    // Reset in the middle of a stalled ACCESS phase.
    slave_stuck = 1'b1;
    cmd_write_i = 1'b0; cmd_addr_i = 16'h0020; cmd_req_i = 1'b1;
    nack = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (cmd_ack_o || irq_ack_o) nack++;
    end
    chk("rst_pre_penable", 32'(penable_o), 32'd1);
    rst_i = 1'b1;
    tick();
    check_zero("midrst");
    rst_i = 1'b0;
    slave_stuck = 1'b0; slave_wait = 0; slave_rdata = 32'h0BAD_F00D;
    tick();
    if (cmd_ack_o || irq_ack_o) nack++;
    chk("rst_restart_psel",    32'(psel_o),    32'd1);
    chk("rst_restart_penable", 32'(penable_o), 32'd0);
    chk("rst_restart_paddr",   paddr_o,        32'h0000_0080);
    tick();
    if (cmd_ack_o || irq_ack_o) nack++;
    chk("rst_no_ack", 32'(nack), 32'd0);
    tick();
    chk("rst_restart_ack",   32'(cmd_ack_o), 32'd1);
    chk("rst_restart_rdata", cmd_rdata_o,    32'h0BAD_F00D);
    cmd_req_i = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
